// File: rtl/abr_dom_and_seq.sv
// Sequencer in front of a 2-share DOM AND multiplier (Pipeline=0): fetches or recycles a mask,
// holds operands stable for LOAD+CAPT, pulses mask-valid once, then returns the product shares.
module abr_dom_and_seq #(
  parameter int unsigned DW       = 64,
  parameter bit          ReusePrd = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  output logic          rnd_req_o,
  input  logic          rnd_ack_i,
  input  logic [DW-1:0] rnd_data_i,
  output logic [DW-1:0] dom_a0_o,
  output logic [DW-1:0] dom_a1_o,
  output logic [DW-1:0] dom_b0_o,
  output logic [DW-1:0] dom_b1_o,
  output logic [DW-1:0] dom_z_o,
  output logic          dom_z_valid_o,
  input  logic [DW-1:0] dom_q0_i,
  input  logic [DW-1:0] dom_q1_i,
  input  logic [DW-1:0] dom_prd_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] q0_o,
  output logic [DW-1:0] q1_o
);

  typedef enum logic [2:0] {S_IDLE, S_RND, S_LOAD, S_CAPT, S_OUT} state_e;

  state_e        r_state;
  state_e        w_next;
  logic [DW-1:0] r_a0, r_a1, r_b0, r_b1, r_z;
  logic [DW-1:0] r_q0, r_q1, r_prd;
  logic          r_prd_avail;
  logic          w_reuse_hit;

  assign w_reuse_hit = ReusePrd && r_prd_avail;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_i) w_next = w_reuse_hit ? S_LOAD : S_RND;
      S_RND:   if (rnd_ack_i) w_next = S_LOAD;
      S_LOAD:  w_next = S_CAPT;
      S_CAPT:  w_next = S_OUT;
      S_OUT:   if (out_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o    = 1'b0;
    rnd_req_o     = 1'b0;
    dom_z_valid_o = 1'b0;
    out_valid_o   = 1'b0;
    case (r_state)
      S_IDLE:  in_ready_o    = 1'b1;
      S_RND:   rnd_req_o     = 1'b1;
      S_LOAD:  dom_z_valid_o = 1'b1;
      S_OUT:   out_valid_o   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a0        <= '0;
      r_a1        <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_z         <= '0;
      r_q0        <= '0;
      r_q1        <= '0;
      r_prd       <= '0;
      r_prd_avail <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid_i) begin
          r_a0 <= a0_i;
          r_a1 <= a1_i;
          r_b0 <= b0_i;
          r_b1 <= b1_i;
          // a stored prd word stands in for one entropy request, then is spent
          if (w_reuse_hit) begin
            r_z         <= r_prd;
            r_prd_avail <= 1'b0;
          end
        end
        S_RND: if (rnd_ack_i) r_z <= rnd_data_i;
        S_CAPT: begin
          r_q0 <= dom_q0_i;
          r_q1 <= dom_q1_i;
          if (ReusePrd) begin
            r_prd       <= dom_prd_i;
            r_prd_avail <= 1'b1;
          end
        end
        S_OUT: if (out_ready_i) begin
          // scrub shares and mask so the multiplier inputs sit at zero while idle
          r_a0 <= '0;
          r_a1 <= '0;
          r_b0 <= '0;
          r_b1 <= '0;
          r_z  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign dom_a0_o = r_a0;
  assign dom_a1_o = r_a1;
  assign dom_b0_o = r_b0;
  assign dom_b1_o = r_b1;
  assign dom_z_o  = r_z;
  assign q0_o     = r_q0;
  assign q1_o     = r_q1;

endmodule

// File: tb/tb_abr_dom_and_seq.sv
// Bench: instance 0 has ReusePrd=0, instance 1 ReusePrd=1; each drives a behavioural DOM AND stub.
module tb_abr_dom_and_seq;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid[N], in_ready[N], rnd_req[N], rnd_ack[N], zv[N], ov[N], out_ready[N];
  logic [7:0] a0[N], a1[N], b0[N], b1[N], rnd_data[N];
  logic [7:0] da0[N], da1[N], db0[N], db1[N], dz[N], q0[N], q1[N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [7:0] sq0, sq1, sprd;
    // DOM AND, one register stage: q0^q1 == (a0^a1)&(b0^b1)
    always @(posedge clk) begin
      sq0  <= (da0[g] & db0[g]) ^ ((da0[g] & db1[g]) ^ dz[g]);
      sq1  <= (da1[g] & db1[g]) ^ ((da1[g] & db0[g]) ^ dz[g]);
      sprd <= (da0[g] & db1[g]) ^ dz[g] ^ 8'h96;
    end
    abr_dom_and_seq #(.DW(8), .ReusePrd(g == 1)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
      .a0_i(a0[g]), .a1_i(a1[g]), .b0_i(b0[g]), .b1_i(b1[g]),
      .rnd_req_o(rnd_req[g]), .rnd_ack_i(rnd_ack[g]), .rnd_data_i(rnd_data[g]),
      .dom_a0_o(da0[g]), .dom_a1_o(da1[g]), .dom_b0_o(db0[g]), .dom_b1_o(db1[g]),
      .dom_z_o(dz[g]), .dom_z_valid_o(zv[g]),
      .dom_q0_i(sq0), .dom_q1_i(sq1), .dom_prd_i(sprd),
      .out_valid_o(ov[g]), .out_ready_i(out_ready[g]),
      .q0_o(q0[g]), .q1_o(q1[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks busy, mask availability and cycles since the mask was known.
  bit         m_busy[N], m_have[N], m_avail[N];
  int         m_cnt[N];
  logic [7:0] ma0[N], ma1[N], mb0[N], mb1[N], m_mask[N], m_res[N], m_prd[N];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        m_busy[k] <= 0; m_have[k] <= 0; m_avail[k] <= 0; m_cnt[k] <= 0;
      end else if (!m_busy[k]) begin
        if (in_valid[k]) begin
          m_busy[k] <= 1;
          ma0[k] <= a0[k]; ma1[k] <= a1[k]; mb0[k] <= b0[k]; mb1[k] <= b1[k];
          m_res[k] <= (a0[k] ^ a1[k]) & (b0[k] ^ b1[k]);
          if (k == 1 && m_avail[k]) begin
            m_mask[k] <= m_prd[k]; m_avail[k] <= 0; m_have[k] <= 1; m_cnt[k] <= 1;
          end else begin
            m_have[k] <= 0;
          end
        end
      end else if (!m_have[k]) begin
        if (rnd_ack[k]) begin
          m_mask[k] <= rnd_data[k]; m_have[k] <= 1; m_cnt[k] <= 1;
        end
      end else begin
        if (m_cnt[k] < 3) m_cnt[k] <= m_cnt[k] + 1;
        if (m_cnt[k] == 2 && k == 1) begin
          m_prd[k] <= (ma0[k] & mb1[k]) ^ m_mask[k] ^ 8'h96;
          m_avail[k] <= 1;
        end
        if (m_cnt[k] >= 3 && out_ready[k]) begin
          m_busy[k] <= 0; m_have[k] <= 0; m_cnt[k] <= 0;
        end
      end
    end
  end

  logic       pov[N], pzv[N];
  logic [7:0] pq0[N], pq1[N];

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        pov[k] = 0; pzv[k] = 0;
      end else begin
        chk($sformatf("in_ready%0d", k), in_ready[k], !m_busy[k]);
        chk($sformatf("rnd_req%0d", k), rnd_req[k], m_busy[k] && !m_have[k]);
        chk($sformatf("z_valid%0d", k), zv[k], m_have[k] && m_cnt[k] == 1);
        chk($sformatf("out_valid%0d", k), ov[k], m_have[k] && m_cnt[k] >= 3);
        chk($sformatf("zv_twice%0d", k), pzv[k] & zv[k], 0);
        if (m_have[k] && (m_cnt[k] == 1 || m_cnt[k] == 2))
          chk($sformatf("dom_hold%0d", k), {da0[k], da1[k], db0[k], db1[k], dz[k]},
              {ma0[k], ma1[k], mb0[k], mb1[k], m_mask[k]});
        if (!m_busy[k])
          chk($sformatf("dom_idle%0d", k), {da0[k], da1[k], db0[k], db1[k], dz[k]}, 0);
        if (m_have[k] && m_cnt[k] >= 3)
          chk($sformatf("unmask%0d", k), q0[k] ^ q1[k], m_res[k]);
        if (pov[k] && ov[k])
          chk($sformatf("q_stable%0d", k), {q0[k], q1[k]}, {pq0[k], pq1[k]});
        pov[k] = ov[k]; pzv[k] = zv[k]; pq0[k] = q0[k]; pq1[k] = q1[k];
      end
    end
  end

  // Event recorder used by the directed literal checks.
  int         rec_req[N], rec_zv[N], rec_zv_cyc[N], rec_out_cyc[N];
  logic [7:0] rec_zv_z[N], rec_res[N];
  logic       rec_pov[N];
  initial for (int k = 0; k < N; k++) begin
    rec_req[k] = 0; rec_zv[k] = 0; rec_zv_cyc[k] = 0; rec_out_cyc[k] = 0; rec_pov[k] = 0;
  end
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rnd_req[k]) rec_req[k]++;
      if (zv[k]) begin rec_zv[k]++; rec_zv_cyc[k] = cyc; rec_zv_z[k] = dz[k]; end
      if (ov[k] && !rec_pov[k]) rec_out_cyc[k] = cyc;
      if (ov[k]) rec_res[k] = q0[k] ^ q1[k];
      rec_pov[k] = ov[k];
    end
  end

  task automatic do_op(input int k, input logic [7:0] x0, x1, y0, y1, input int d,
                       input logic [7:0] data, input int rw, input bit poke,
                       output int reqs, output int zvs, output int zv_rel,
                       output logic [7:0] zval, output int out_rel, output logic [7:0] res);
    int hs, req0, zv0, i;
    req0 = rec_req[k]; zv0 = rec_zv[k];
    a0[k] = x0; a1[k] = x1; b0[k] = y0; b1[k] = y1;
    in_valid[k] = 1; hs = cyc;
    @(posedge clk) #1; in_valid[k] = 0;
    repeat (d) @(posedge clk) #1;
    rnd_ack[k] = 1; rnd_data[k] = data;
    @(posedge clk) #1; rnd_ack[k] = 0; rnd_data[k] = 8'h00;
    i = 0;
    while (!ov[k] && i < 50) begin @(posedge clk) #1; i++; end
    if (!ov[k]) chk("out_valid_timeout", 0, 1);
    for (int j = 0; j < rw; j++) begin
      if (poke && j == 5) begin
        a0[k] = ~x0; b1[k] = ~y1; in_valid[k] = 1;
        chk("busy_in_ready", in_ready[k], 0);
      end
      @(posedge clk) #1; in_valid[k] = 0;
    end
    out_ready[k] = 1;
    @(posedge clk) #1; out_ready[k] = 0;
    reqs = rec_req[k] - req0; zvs = rec_zv[k] - zv0;
    zv_rel = rec_zv_cyc[k] - hs; zval = rec_zv_z[k];
    out_rel = rec_out_cyc[k] - hs; res = rec_res[k];
  endtask

  int         reqs, zvs, zv_rel, out_rel;
  logic [7:0] zval, res, r0, r1, r2, r3, rd;

  initial begin
    rst = 1;
    for (int k = 0; k < N; k++) begin
      in_valid[k] = 0; rnd_ack[k] = 0; out_ready[k] = 0; rnd_data[k] = 0;
      a0[k] = 0; a1[k] = 0; b0[k] = 0; b1[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_in_ready", in_ready[k], 1);
      chk("rst_ctrl", {ov[k], rnd_req[k], zv[k]}, 0);
      chk("rst_data", {q0[k], q1[k], dz[k], da0[k]}, 0);
    end
    @(posedge clk) #1;

    // immediate ack
    do_op(0, 8'h5A, 8'hAA, 8'h11, 8'h2D, 0, 8'hC3, 0, 0, reqs, zvs, zv_rel, zval, out_rel, res);
    chk("t1_zv_cycle", zv_rel, 2);
    chk("t1_zv_count", zvs, 1);
    chk("t1_out_cycle", out_rel, 4);
    chk("t1_result", res, 8'h30);
    chk("t1_mask", zval, 8'hC3);

    // ack delayed five cycles
    do_op(0, 8'h5A, 8'hAA, 8'h11, 8'h2D, 5, 8'hC3, 0, 0, reqs, zvs, zv_rel, zval, out_rel, res);
    chk("t2_req_cycles", reqs, 6);
    chk("t2_out_cycle", out_rel, 9);
    chk("t2_result", res, 8'h30);

    // prd reuse: prd of first op = (5A&2D)^C3^96 = 5D
    do_op(1, 8'h5A, 8'hAA, 8'h11, 8'h2D, 0, 8'hC3, 0, 0, reqs, zvs, zv_rel, zval, out_rel, res);
    chk("t3a_reqs", reqs, 1);
    chk("t3a_out_cycle", out_rel, 4);
    do_op(1, 8'h0F, 8'hF0, 8'h03, 8'h0C, 0, 8'hE7, 0, 0, reqs, zvs, zv_rel, zval, out_rel, res);
    chk("t3b_reqs", reqs, 0);
    chk("t3b_mask", zval, 8'h5D);
    chk("t3b_zv_cycle", zv_rel, 1);
    chk("t3b_out_cycle", out_rel, 3);
    chk("t3b_result", res, 8'h0F);

    // backpressure with an ignored in_valid pulse
    do_op(0, 8'h0F, 8'hF0, 8'h03, 8'h0C, 1, 8'h3C, 10, 1, reqs, zvs, zv_rel, zval, out_rel, res);
    chk("t4_result", res, 8'h0F);
    chk("t4_scrub", {da0[0], da1[0], db0[0], db1[0], dz[0]}, 0);
    chk("t4_in_ready", in_ready[0], 1);
    repeat (3) @(posedge clk) #1;
    chk("t4_no_second_op", {ov[0], rnd_req[0]}, 0);

    // reset while instance 1 is in LOAD (prd hit)
    a0[1] = 8'h33; a1[1] = 8'h44; b0[1] = 8'h55; b1[1] = 8'h66; in_valid[1] = 1;
    @(posedge clk) #1; in_valid[1] = 0;
    chk("t5_in_load", zv[1], 1);
    rst = 1;
    #1;
    chk("t5_in_ready", in_ready[1], 1);
    chk("t5_ctrl", {zv[1], ov[1], rnd_req[1]}, 0);
    chk("t5_data", {da0[1], da1[1], db0[1], db1[1], dz[1], q0[1], q1[1]}, 0);
    @(posedge clk) #1; rst = 0;
    @(posedge clk) #1;
    do_op(1, 8'h5A, 8'hAA, 8'h11, 8'h2D, 0, 8'h81, 0, 0, reqs, zvs, zv_rel, zval, out_rel, res);
    chk("t5_reqs_after_rst", reqs, 1);
    chk("t5_mask", zval, 8'h81);
    chk("t5_result", res, 8'h30);

    // random regression
    for (int n = 0; n < 1000; n++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      rd = 8'($urandom);
      do_op(n % 2, r0, r1, r2, r3, $urandom_range(0, 3), rd, $urandom_range(0, 2), 0,
            reqs, zvs, zv_rel, zval, out_rel, res);
      chk("rand_result", res, (r0 ^ r1) & (r2 ^ r3));
      chk("rand_zv_once", zvs, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abr_dom_and_seq.md
Name: abr_dom_and_seq

Overview:
- Sequencer that sits directly upstream of a 2-share DOM GF(2) AND multiplier instantiated with Pipeline=0.
- Accepts one masked operand pair per transaction over valid/ready and obtains a fresh mask word from the entropy interface.
- Drives the multiplier with operands held stable for the two required cycles and pulses the multiplier's randomness-valid input.
- Captures the product shares and the multiplier's pseudo-random output, then returns the result over valid/ready. Optionally recycles that pseudo-random output as the next mask.

Parameters:
- DW, 64, share width in bits; must match the multiplier's DW.
- ReusePrd, 1'b0, when 1 a stored pseudo-random word from the previous operation replaces one entropy request.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  sequencer can accept operands.
- a0_i, a1_i, b0_i, b1_i  in  DW each  operand shares.
- rnd_req_o  out  1  entropy request.
- rnd_ack_i  in  1  entropy word valid this cycle.
- rnd_data_i  in  DW  entropy word.
- dom_a0_o, dom_a1_o, dom_b0_o, dom_b1_o  out  DW each  operand shares to the multiplier.
- dom_z_o  out  DW  mask to the multiplier.
- dom_z_valid_o  out  1  mask-valid pulse to the multiplier.
- dom_q0_i, dom_q1_i  in  DW each  product shares from the multiplier.
- dom_prd_i  in  DW  pseudo-random output of the multiplier.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- q0_o, q1_o  out  DW each  registered result shares.

Behaviour:
- Reset (asynchronous assert, synchronous deassert into IDLE):
  - All operand, mask, result and prd registers clear to 0; prd_avail clears to 0.
  - All outputs are 0 except in_ready_o=1.
  - A reset mid-transaction abandons it; no partial result is ever presented.
- FSM states: IDLE, RND, LOAD, CAPT, OUT. Exactly one state active.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i, register a0/a1/b0/b1.
  - If ReusePrd=1 and prd_avail=1: copy the prd register to the mask register, clear prd_avail, go to LOAD.
  - Otherwise go to RND.
- RND:
  - rnd_req_o=1, held until ack.
  - On rnd_ack_i, latch rnd_data_i into the mask register and go to LOAD.
  - rnd_ack_i in any other state is ignored.
- LOAD:
  - dom_z_valid_o=1 for exactly this one cycle; go to CAPT.
- CAPT:
  - dom_z_valid_o=0; operand and mask outputs unchanged from LOAD.
  - Latch dom_q0_i/dom_q1_i into q0_o/q1_o.
  - Latch dom_prd_i into the prd register and set prd_avail=1; with ReusePrd=0 neither register is latched.
  - Go to OUT.
- OUT:
  - out_valid_o=1; q0_o/q1_o held stable until accepted.
  - On out_ready_i: go to IDLE; clear the operand and mask registers to 0 (scrub); out_valid_o drops next cycle.
- Output drive:
  - dom_* operand and mask outputs come directly from registers, never from the inputs combinationally.
  - They are stable from LOAD through CAPT and zero in IDLE after scrub.
- Latency:
  - Input handshake at cycle 0, ack in first RND cycle (cycle 1): LOAD at 2, CAPT at 3, out_valid_o=1 at 4.
  - Each extra RND wait cycle adds 1.
  - With a prd reuse hit: LOAD at 1, out_valid_o=1 at 3.
- Throughput: no overlap; in_ready_o=0 from the cycle after the handshake until return to IDLE.
- prd_avail:
  - Persists across idle periods and is consumed by at most one operation.
  - It is not regenerated until a new CAPT occurs.
- in_valid_i outside IDLE is ignored; operand inputs may change freely while busy.
- Invariant: q0_o^q1_o == (a0^a1)&(b0^b1) of the accepted operands whenever out_valid_o=1.

Test Plan:
- DW=8, ReusePrd=0, a0=0x5A a1=0xAA b0=0x11 b1=0x2D, rnd_ack_i asserted on the first rnd_req_o cycle with data 0xC3:
  - dom_z_valid_o high in cycle 2 only.
  - out_valid_o high at cycle 4.
  - q0_o^q1_o=0x30.
- Same operands, rnd_ack_i delayed 5 cycles: rnd_req_o is held 6 cycles; out_valid_o rises 5 cycles later than in the first scenario; the result is unchanged.
- ReusePrd=1, two back-to-back ops (second a=0xFF, b=0x0F as shares 0x0F/0xF0, 0x03/0x0C):
  - First op requests entropy; second op issues no rnd_req_o.
  - Second op's dom_z_o equals the dom_prd_i captured in the first op's CAPT.
  - Second op's q0_o^q1_o=0x0F.
- Backpressure: out_ready_i low for 10 cycles in OUT; q0_o/q1_o stable, in_ready_o=0, an in_valid_i pulse is ignored; after accept, dom_a0_o..dom_z_o read 0.
- rst_i asserted during LOAD: all outputs go to 0 and in_ready_o to 1 immediately; prd_avail=0; the next op requests entropy even with ReusePrd=1.
- Random regression of 1000 ops with random ack delays 0..3: every result satisfies the unmasking invariant; dom_z_valid_o is never high in two consecutive cycles.
